// File: rtl/hazard_forward_unit_if.sv
// ID-stage request and hazard/forward response bundle for hazard_forward_unit.
interface hazard_forward_unit_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3
);
  localparam int SEL_W = $clog2(DEPTH);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic              id_regwrite;
  logic              id_memread;
  logic              flush;
  logic              stall;
  logic [SEL_W-1:0]  fwd_a;
  logic [SEL_W-1:0]  fwd_b;
  logic [31:0]       stall_count;
  logic [31:0]       fwd_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
           id_regwrite, id_memread, flush,
    input  stall, fwd_a, fwd_b, stall_count, fwd_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
           id_regwrite, id_memread, flush,
    output stall, fwd_a, fwd_b, stall_count, fwd_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Load-use stall and operand-forward selection driven by a shadow pipeline of
// in-flight instructions. Optional statistics counters: define HFU_STATS_EN.
module hazard_forward_unit #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_forward_unit_if.slave bus
);
  localparam int SEL_W = $clog2(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } slot_t;

  slot_t            slots [DEPTH];
  slot_t            id_slot;
  logic             haz_a;
  logic             haz_b;
  logic             stall;
  logic [SEL_W-1:0] fwd_a;
  logic [SEL_W-1:0] fwd_b;

  function automatic logic produces(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.regwrite && (s.rd != '0) && (s.rd == r);
  endfunction

  always_comb begin
    id_slot          = '0;
    id_slot.valid    = 1'b1;
    id_slot.rs1      = bus.id_rs1;
    id_slot.rs2      = bus.id_rs2;
    id_slot.rs1_used = bus.id_rs1_used;
    id_slot.rs2_used = bus.id_rs2_used;
    id_slot.rd       = bus.id_rd;
    id_slot.regwrite = bus.id_regwrite;
    id_slot.memread  = bus.id_memread;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) slots[k] <= '0;
    end else begin
      slots[0] <= (bus.id_valid && !stall && !bus.flush) ? id_slot : '0;
      slots[1] <= bus.flush ? '0 : slots[0];
      for (int unsigned k = 2; k < DEPTH; k++) slots[k] <= slots[k-1];
    end
  end

  // Scan oldest to youngest so the last hit is the nearest producer.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
      if (slots[0].valid && slots[0].rs1_used && produces(slots[k], slots[0].rs1))
        fwd_a = SEL_W'(k);
      if (slots[0].valid && slots[0].rs2_used && produces(slots[k], slots[0].rs2))
        fwd_b = SEL_W'(k);
    end
  end

  // j is slot index + 1; a younger non-load producer overrides an older load.
  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int unsigned j = DEPTH - 1; j > 0; j--) begin
      if (produces(slots[j-1], bus.id_rs1))
        haz_a = slots[j-1].memread && (j <= LOAD_LAT);
      if (produces(slots[j-1], bus.id_rs2))
        haz_b = slots[j-1].memread && (j <= LOAD_LAT);
    end
    stall = bus.id_valid && !bus.flush &&
            ((bus.id_rs1_used && haz_a) || (bus.id_rs2_used && haz_b));
  end

  assign bus.stall = stall;
  assign bus.fwd_a = fwd_a;
  assign bus.fwd_b = fwd_b;

`ifdef HFU_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if ((fwd_a != '0 || fwd_b != '0) && fwd_cnt != '1)
        fwd_cnt <= fwd_cnt + 32'd1;
    end
  end

  assign bus.stall_count = stall_cnt;
  assign bus.fwd_count   = fwd_cnt;
`else
  assign bus.stall_count = '0;
  assign bus.fwd_count   = '0;
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: DEPTH=3/LOAD_LAT=1 and DEPTH=4/LOAD_LAT=2 instances.
module tb_hazard_forward_unit;
`ifdef HFU_STATS_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_AW(5), .DEPTH(3)) b0 ();
  hazard_forward_unit_if #(.REG_AW(5), .DEPTH(4)) b1 ();

  hazard_forward_unit #(.REG_AW(5), .DEPTH(3), .LOAD_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );
  hazard_forward_unit #(.REG_AW(5), .DEPTH(4), .LOAD_LAT(2)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  typedef struct {
    string name;
    int    st;
    int    fa;
    int    fb;
    int    sc;
    int    fc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;

  task automatic drive(input int v, input int rs1, input int rs2, input int rd,
                       input int u1, input int u2, input int rw, input int mr,
                       input int fl);
    b0.id_valid = 1'(v);  b0.id_rs1 = 5'(rs1); b0.id_rs2 = 5'(rs2); b0.id_rd = 5'(rd);
    b0.id_rs1_used = 1'(u1); b0.id_rs2_used = 1'(u2);
    b0.id_regwrite = 1'(rw); b0.id_memread = 1'(mr); b0.flush = 1'(fl);
    b1.id_valid = 1'(v);  b1.id_rs1 = 5'(rs1); b1.id_rs2 = 5'(rs2); b1.id_rd = 5'(rd);
    b1.id_rs1_used = 1'(u1); b1.id_rs2_used = 1'(u2);
    b1.id_regwrite = 1'(rw); b1.id_memread = 1'(mr); b1.flush = 1'(fl);
  endtask

  task automatic bub();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic e0(input string n, input int st, input int fa, input int fb,
                    input int sc, input int fc);
    q0.push_back('{name: n, st: st, fa: fa, fb: fb, sc: sc * S, fc: fc * S});
  endtask

  task automatic e1(input string n, input int st, input int fa, input int fb,
                    input int sc, input int fc);
    q1.push_back('{name: n, st: st, fa: fa, fb: fb, sc: sc * S, fc: fc * S});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string dut, input exp_t e, input int st, input int fa,
                     input int fb, input int sc, input int fc);
    tests++;
    if (st != e.st || fa != e.fa || fb != e.fb || sc != e.sc || fc != e.fc) begin
      fails++;
      $display("FAIL %s %s: got stall=%0d fwd_a=%0d fwd_b=%0d stall_count=%0d fwd_count=%0d, expected stall=%0d fwd_a=%0d fwd_b=%0d stall_count=%0d fwd_count=%0d",
               dut, e.name, st, fa, fb, sc, fc, e.st, e.fa, e.fb, e.sc, e.fc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp("dut0", e, int'(b0.stall), int'(b0.fwd_a), int'(b0.fwd_b),
          int'(b0.stall_count), int'(b0.fwd_count));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp("dut1", e, int'(b1.stall), int'(b1.fwd_a), int'(b1.fwd_b),
          int'(b1.stall_count), int'(b1.fwd_count));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bub();
    #2 reset = 1'b0;
    tick();
    // Load-use request held during reset must not reach the slots.
    drive(1, 5, 5, 5, 1, 1, 1, 1, 0);
    e0("reset_state", 0, 0, 0, 0, 0); e1("reset_state", 0, 0, 0, 0, 0);
    tick();
    e0("reset_hold", 0, 0, 0, 0, 0); e1("reset_hold", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;

    drive(1, 1, 2, 5, 1, 1, 1, 0, 0); e0("alu_issue", 0, 0, 0, 0, 0); tick();
    drive(1, 5, 1, 6, 1, 1, 1, 0, 0); e0("alu_dep_no_stall", 0, 0, 0, 0, 0); tick();
    bub();                            e0("alu_fwd_slot1", 0, 1, 0, 0, 0); tick();
    bub();                            e0("alu_fwd_clear", 0, 0, 0, 0, 1); tick();

    drive(1, 2, 0, 5, 1, 0, 1, 1, 0); e0("load_issue", 0, 0, 0, 0, 1); tick();
    drive(1, 5, 3, 7, 1, 1, 1, 0, 0); e0("load_use_stall", 1, 0, 0, 0, 1); tick();
    drive(1, 5, 3, 7, 1, 1, 1, 0, 0); e0("load_use_release", 0, 0, 0, 1, 1); tick();
    bub();                            e0("load_fwd_slot2", 0, 2, 0, 1, 1); tick();
    bub();                            e0("load_fwd_clear", 0, 0, 0, 1, 2); tick();

    drive(1, 1, 0, 7, 1, 0, 1, 1, 0); e0("shadow_ld", 0, 0, 0, 1, 2); tick();
    drive(1, 2, 3, 7, 1, 1, 1, 0, 0); e0("shadow_add", 0, 0, 0, 1, 2); tick();
    drive(1, 7, 7, 8, 1, 1, 1, 0, 0); e0("shadow_no_stall", 0, 0, 0, 1, 2); tick();
    bub();                            e0("shadow_fwd_add", 0, 1, 1, 1, 2); tick();
    bub();                            e0("shadow_clear", 0, 0, 0, 1, 3); tick();

    drive(1, 1, 0, 3, 1, 0, 1, 1, 0); e0("flush_ld", 0, 0, 0, 1, 3); tick();
    drive(1, 3, 3, 3, 1, 1, 1, 0, 1); e0("flush_masks_stall", 0, 0, 0, 1, 3); tick();
    drive(1, 3, 0, 10, 1, 0, 1, 0, 0); e0("flush_slot0_bubble", 0, 0, 0, 1, 3); tick();
    bub();                            e0("flush_slot1_bubble", 0, 0, 0, 1, 3); tick();

    drive(1, 0, 0, 0, 1, 1, 1, 0, 0); e0("x0_add", 0, 0, 0, 1, 3); tick();
    drive(1, 0, 0, 0, 1, 1, 1, 1, 0); e0("x0_ld", 0, 0, 0, 1, 3); tick();
    drive(1, 0, 0, 0, 1, 1, 1, 0, 0); e0("x0_no_stall", 0, 0, 0, 1, 3); tick();
    bub();                            e0("x0_no_fwd", 0, 0, 0, 1, 3); tick();

    reset = 1'b0; tick(); reset = 1'b1;
    drive(1, 1, 0, 9, 1, 0, 1, 1, 0); e1("d4_ld", 0, 0, 0, 0, 0); tick();
    drive(1, 9, 2, 11, 1, 1, 1, 0, 0); e1("d4_stall_1", 1, 0, 0, 0, 0); tick();
    drive(1, 9, 2, 11, 1, 1, 1, 0, 0); e1("d4_stall_2", 1, 0, 0, 1, 0); tick();
    drive(1, 9, 2, 11, 1, 1, 1, 0, 0); e1("d4_release", 0, 0, 0, 2, 0); tick();
    bub();                             e1("d4_fwd_slot3", 0, 3, 0, 2, 0); tick();
    bub();                             e1("d4_fwd_clear", 0, 0, 0, 2, 1); tick();

    reset = 1'b0; tick(); reset = 1'b1;
    drive(1, 1, 0, 9, 1, 0, 1, 1, 0); e1("d4r_ld", 0, 0, 0, 0, 0); tick();
    drive(1, 9, 2, 11, 1, 1, 1, 0, 0); e1("d4r_stall_1", 1, 0, 0, 0, 0); tick();
    // Reset lands between the edge and the sample, so only an async clear passes.
    e1("d4r_reset_mid_stall", 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    tick();
    e1("d4r_reset_hold", 0, 0, 0, 0, 0); tick();
    reset = 1'b1;
    bub();
    tick();
    tick();

    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending entries, expected 0/0",
               q0.size(), q1.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter DEPTH, default 3, shadow-pipeline slots (slot 0 = EX, slot 1 = MEM, slot 2 = WB, ...); legal range 2..8.
REQ-003 Parameter LOAD_LAT, default 1, stages after EX before load data is forwardable; legal range 1..DEPTH-1.
REQ-004 clk  input  1  the only clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 id_valid  input  1  ID-stage instruction present.
REQ-007 id_rs1, id_rs2, id_rd  input  REG_AW  ID-stage register addresses.
REQ-008 id_rs1_used, id_rs2_used  input  1  ID instruction reads rs1/rs2.
REQ-009 id_regwrite, id_memread  input  1  ID instruction writes rd / is a load.
REQ-010 flush  input  1  squash the ID and EX instructions (taken branch).
REQ-011 stall  output  1  hold PC and IF/ID and insert a bubble into EX.
REQ-012 fwd_a, fwd_b  output  SEL_W=$clog2(DEPTH)  EX operand source: 0 = register file, k = slot k result.
REQ-013 stall_count, fwd_count  output  32  statistics counters (see Configuration).

Function
REQ-014 Each slot SHALL hold {valid, rs1, rs2, rs1_used, rs2_used, rd, regwrite, memread}.
REQ-015 Each rising edge SHALL shift slot k into slot k+1 for k = 0..DEPTH-2; slot DEPTH-1 contents SHALL be discarded.
REQ-016 Slot 0 SHALL load the ID fields with valid=1 when id_valid=1, stall=0 and flush=0; otherwise it SHALL load a bubble (valid=0).
REQ-017 When flush=1, slot 1 SHALL also receive a bubble instead of the old slot 0 contents.
REQ-018 A slot k "produces rX" when valid=1, regwrite=1, rd!=0 and rd==rX.
REQ-019 fwd_a SHALL equal the smallest k in 1..DEPTH-1 whose slot produces slot 0's rs1, provided slot 0 is valid and rs1_used=1; otherwise 0. fwd_b is the same for rs2.
REQ-020 fwd_a and fwd_b SHALL depend only on registered state (no combinational path from inputs).
REQ-021 A hazard exists for operand X when id_valid=1, idX_used=1, and the youngest slot j (0..DEPTH-2) producing idX has memread=1 and j+1 <= LOAD_LAT.
REQ-022 stall SHALL be combinational: 1 when a hazard exists on rs1 or rs2 and flush=0; otherwise 0.
REQ-023 An older load shadowed by a younger non-load producer of the same register SHALL NOT cause a stall.
REQ-024 Register x0 SHALL never produce a forward or a stall.
REQ-025 A stall SHALL last exactly LOAD_LAT-j cycles for a hazard at slot j, with no ID input change required between cycles.
REQ-026 Writeback beyond slot DEPTH-1 SHALL be covered by register-file write-through; no forward is generated for it.

Reset
REQ-027 While reset=0, all slot valid bits SHALL clear asynchronously.
REQ-028 While reset=0, stall, fwd_a, fwd_b, stall_count and fwd_count SHALL read 0.
REQ-029 Assertion of reset mid-stall SHALL drop stall to 0 immediately.
REQ-030 The first edge after reset deassertion SHALL load slot 0 normally.

Configuration
REQ-031 Macro HFU_STATS_EN.
- Defined: stall_count increments on each cycle with stall=1; fwd_count increments on each cycle with fwd_a!=0 or fwd_b!=0. Both saturate at 0xFFFFFFFF; flush does not clear them.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Verification
REQ-032 Slot 0: add x5. ID: add x6,x5,x1 -> stall=0; next cycle fwd_a=1, fwd_b=0.
REQ-033 Slot 0: ld x5. ID uses x5, LOAD_LAT=1 -> stall=1 for one cycle; EX bubble; then fwd_a=2, stall_count=1.
REQ-034 Slot 1: ld x7; slot 0: add x7. ID reads x7 -> no stall; next cycle fwd=1, taken from the add.
REQ-035 Slot 0: ld x3 with flush=1 while ID reads x3 -> stall=0; slots 0 and 1 become bubbles next cycle.
REQ-036 Producer rd=x0 in every slot, ID reads x0 -> stall=0, fwd_a=fwd_b=0.
REQ-037 DEPTH=4, LOAD_LAT=2, slot 0: ld x9, ID reads x9 -> stall=2 cycles; reset=0 asserted in cycle 2 -> stall=0 immediately, counters 0.
